seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Time-multiplexed driver for a bank of `NUM_DIGITS` common-anode seven-segment digits sharing one segment bus. It holds a double-buffered frame of hex nibbles with per-digit blank and decimal-point bits, and scans the digits at a fixed refresh rate. A dead-time guard after each digit switch suppresses ghosting. It sits between the application logic and the board display pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned; ≥2.
- `CLK_HZ`, 100_000_000: clock frequency.
- `FRAME_HZ`, 1000: full-frame refresh rate.
- `GUARD`, 2: dead-time cycles with all anodes off after each switch.
- `ACTIVE_LOW`, 1: 1 means segments, dp and anodes are driven low-active; 0 means high-active.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `digits_i`  in  4*NUM_DIGITS  nibble k at [4k+3:4k]; digit 0 is rightmost.
- `blank_i`  in  NUM_DIGITS  1 means digit dark.
- `dp_i`  in  NUM_DIGITS  1 means decimal point lit.
- `load_i`  in  1  one-cycle strobe that captures the three inputs into the pending buffer.
- `segs_o`  out  7  {G,F,E,D,C,B,A}.
- `dp_o`  out  1  decimal point.
- `an_o`  out  NUM_DIGITS  anode enables, one-hot active.
- `frame_o`  out  1  one-cycle pulse at the start of each frame.

## Operation
- `DIV = CLK_HZ / (FRAME_HZ*NUM_DIGITS)`, computed at elaboration time.
  - Elaboration fails if `DIV < GUARD+1`.
- Slot counter `cnt` counts 0..DIV-1.
  - When `cnt == DIV-1`: `cnt` goes to 0 and `idx` goes to `idx+1`.
  - `idx` wraps from NUM_DIGITS-1 to 0. This wrap is the frame boundary.
- Buffers:
  - `load_i` writes the pending buffer and sets `pend_v`. Multiple loads within one frame: the last one wins.
  - At a frame boundary, if `pend_v` is set, the active buffer takes the pending buffer and `pend_v` clears. Otherwise the active buffer holds.
  - `load_i` on the boundary edge goes to pending only. The active buffer is updated from pending contents captured before that edge.
  - A frame never mixes old and new data.
- Decode: hex 0–F uses the standard pattern. Examples, active-high GFEDCBA:
  - 0 = 0111111
  - 4 = 1100110
  - A = 1110111
  - F = 1110001
- Polarity: with ACTIVE_LOW, all of `segs_o`, `dp_o` and `an_o` are inverted.
- Output rules:
  - Inside the guard window (`cnt < GUARD`): anodes are off, segments are off, dp is off.
  - If the current digit is blanked: its anode stays off for the whole slot.
  - Otherwise: `an_o` selects `idx`, and `segs_o`/`dp_o` show the digit's active-buffer values.

## Timing
- All outputs are registered.
  - They are computed from the post-edge values of `cnt`, `idx` and the active buffer.
  - So on the edge where `idx` changes, outputs switch to the guard state for the new slot.
- Within each slot: GUARD cycles dark, then DIV-GUARD cycles lit.
- `frame_o` is high for exactly the cycle in which `idx==0 && cnt==0`.
- A new load becomes visible at the first frame boundary after it, i.e. within 1 frame + 1 cycle.
- Reset values, which apply immediately and asynchronously, including mid-slot:
  - `cnt = 0`, `idx = 0`, `pend_v = 0`.
  - Active and pending buffers: digits 0, blank all 1, dp all 0.
  - All outputs inactive. `an_o` is all ones with ACTIVE_LOW. `segs_o = 7'h7F`, `dp_o = 1`, `frame_o = 0`.
- After reset deasserts:
  - The first `frame_o` comes at the first clock edge.
  - The display stays dark until a load has occurred and a boundary has passed.

## Structure
- Package `seven_seg_pkg`:
  - Function `hex_to_segs(logic [3:0]) -> logic [6:0]`, active-high.
  - Segment-off constant.
- Sub-module `scan_timer`:
  - Contains the slot counter and digit index.
  - Outputs `idx`, `cnt_zero`, `in_guard`, `frame_start`.
  - Parametrised by DIV, GUARD and NUM_DIGITS.
- The top level owns the buffers, decode, polarity and output registers.

## Test plan
Configuration for all tests: NUM_DIGITS=4, CLK_HZ=4000, FRAME_HZ=100, which gives DIV=10. GUARD=2, ACTIVE_LOW=1.
- Reset then idle: `an_o = 4'b1111`, `segs_o = 7'h7F`, `dp_o = 1` for ≥3 frames, and `frame_o` pulses every 40 cycles.
- Load `digits=16'h1234`, `blank=0`, `dp=4'b0001`, then wait for the boundary. Digit-0 slot shows:
  - 2 cycles of `an_o = 1111`,
  - then 8 cycles of `an_o = 1110`, `segs_o = 7'b0011001` ("4"), `dp_o = 0`.
- Load `16'hFA00`:
  - Slot 3 shows `segs_o = 7'b0001110` ("F").
  - Slot 2 shows `7'b0001000` ("A").
- `blank = 4'b0100`: `an_o` never equals `1011` across 10 frames; other slots are unchanged.
- Mid-frame tearing checks:
  - Load `16'h1111`, then `16'h2222` in the same frame: the next frame shows only `2`. The current frame shows only the old value.
  - `load_i` on the boundary edge: the new data appears one frame later.
- Assert `rst` mid-lit-slot:
  - Outputs go inactive in the same cycle, without waiting for a clock edge.
  - After release, `frame_o` comes at the first edge and the display stays dark.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decoder for the seven-segment scanner.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    // Active-high "all segments off" pattern, {G,F,E,D,C,B,A}.
    localparam logic [SEG_W-1:0] SEGS_OFF = 7'h00;

    // Standard hex glyphs, active-high {G,F,E,D,C,B,A}.
    function automatic logic [SEG_W-1:0] hex_to_segs(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] segs;
        case (nib)
            4'h0:    segs = 7'h3F;
            4'h1:    segs = 7'h06;
            4'h2:    segs = 7'h5B;
            4'h3:    segs = 7'h4F;
            4'h4:    segs = 7'h66;
            4'h5:    segs = 7'h6D;
            4'h6:    segs = 7'h7D;
            4'h7:    segs = 7'h07;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h6F;
            4'hA:    segs = 7'h77;
            4'hB:    segs = 7'h7C;
            4'hC:    segs = 7'h39;
            4'hD:    segs = 7'h5E;
            4'hE:    segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot counter and digit index. The outputs are look-ahead (combinational)
// values describing the state right after the coming clock edge, so the
// top level can register its outputs in step with the counter.
module scan_timer #(
    parameter int unsigned DIV        = 10,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
    output logic                          cnt_zero_o,
    output logic                          in_guard_o,
    output logic                          frame_start_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next slot position; the first edge after reset holds 0/0 so it opens frame 0.
    always_comb begin
        run_d = 1'b1;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o         = idx_d;
    assign cnt_zero_o    = (cnt_d == '0);
    assign in_guard_o    = (32'(cnt_d) < GUARD);
    assign frame_start_o = cnt_zero_o && (idx_d == '0);

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment driver with a double-buffered frame
// and a dark guard window after every digit switch.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned FRAME_HZ   = 1000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NIB_W*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]       blank_i,
    input  logic [NUM_DIGITS-1:0]       dp_i,
    input  logic                        load_i,
    output logic [SEG_W-1:0]            segs_o,
    output logic                        dp_o,
    output logic [NUM_DIGITS-1:0]       an_o,
    output logic                        frame_o
);

    localparam int unsigned DIV   = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DIG_W = NIB_W * NUM_DIGITS;
    localparam logic        POL_LOW = (ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]      SEGS_IDLE = SEGS_OFF ^ {SEG_W{POL_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE   = {NUM_DIGITS{POL_LOW}};

    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("seven_seg_scan: NUM_DIGITS must be at least 2");
    end
    if (DIV < GUARD + 1) begin : g_bad_div
        $error("seven_seg_scan: refresh divider too small for the guard window");
    end

    logic [IDX_W-1:0] idx_c;
    logic             cnt_zero_c;
    logic             in_guard_c;
    logic             frame_start_c;

    scan_timer #(
        .DIV        (DIV),
        .GUARD      (GUARD),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .idx_o         (idx_c),
        .cnt_zero_o    (cnt_zero_c),
        .in_guard_o    (in_guard_c),
        .frame_start_o (frame_start_c)
    );

    logic [DIG_W-1:0]      act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_v_q, pend_v_d;
    logic                  swap_c;

    logic [SEG_W-1:0]      segs_q, segs_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    assign swap_c = pend_v_q && cnt_zero_c && (idx_c == '0);

    // Buffer update: the boundary swap uses pre-edge pending data; a load on the same edge only refills pending.
    always_comb begin
        act_dig_d    = act_dig_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_dig_d   = pend_dig_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_v_d     = pend_v_q;
        if (swap_c) begin
            act_dig_d   = pend_dig_q;
            act_blank_d = pend_blank_q;
            act_dp_d    = pend_dp_q;
            pend_v_d    = 1'b0;
        end
        if (load_i) begin
            pend_dig_d   = digits_i;
            pend_blank_d = blank_i;
            pend_dp_d    = dp_i;
            pend_v_d     = 1'b1;
        end
    end

    logic [NIB_W-1:0]      nib_c;
    logic                  lit_c;
    logic [SEG_W-1:0]      segs_hi_c;
    logic                  dp_hi_c;
    logic [NUM_DIGITS-1:0] an_hi_c;

    // Output pattern for the post-edge slot, then board polarity.
    always_comb begin
        nib_c     = act_dig_d[{idx_c, 2'b00} +: NIB_W];
        lit_c     = !in_guard_c && !act_blank_d[idx_c];
        segs_hi_c = SEGS_OFF;
        dp_hi_c   = 1'b0;
        an_hi_c   = '0;
        if (lit_c) begin
            segs_hi_c = hex_to_segs(nib_c);
            dp_hi_c   = act_dp_d[idx_c];
            an_hi_c   = NUM_DIGITS'(1) << idx_c;
        end
        segs_d  = segs_hi_c ^ {SEG_W{POL_LOW}};
        dp_d    = dp_hi_c ^ POL_LOW;
        an_d    = an_hi_c ^ {NUM_DIGITS{POL_LOW}};
        frame_d = frame_start_c;
    end

    // Frame buffers and output registers; reset leaves the display dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_dig_q    <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            pend_dig_q   <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            pend_v_q     <= 1'b0;
            segs_q       <= SEGS_IDLE;
            dp_q         <= POL_LOW;
            an_q         <= AN_IDLE;
            frame_q      <= 1'b0;
        end else begin
            act_dig_q    <= act_dig_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_dig_q   <= pend_dig_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            segs_q       <= segs_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign segs_o  = segs_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: 4 digits, DIV=10, GUARD=2, active-low outputs.
module tb_seven_seg_scan;

    localparam int unsigned N     = 4;
    localparam int unsigned DIV   = 10;
    localparam int unsigned GUARD = 2;
    localparam int unsigned FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_i;
    logic [3:0]  blank_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic [6:0]  segs_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS (4),
        .CLK_HZ     (4000),
        .FRAME_HZ   (100),
        .GUARD      (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digits_i (digits_i),
        .blank_i  (blank_i),
        .dp_i     (dp_i),
        .load_i   (load_i),
        .segs_o   (segs_o),
        .dp_o     (dp_o),
        .an_o     (an_o),
        .frame_o  (frame_o)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] segs;
        logic       dp;
        logic       frame;
    } out_t;

    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: time since reset release plus the two frame buffers.
    int unsigned k;
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_b, m_pend_b, m_act_p, m_pend_p;
    logic        m_pend_v;
    logic [15:0] st_d;
    logic [3:0]  st_b, st_p;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0111111;  4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;  4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;  4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;  4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;  4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;  4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;  4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;  default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] lo(input logic [3:0] h);
        return ~seg_ref(h);
    endfunction

    task automatic model_reset();
        k        = 0;
        m_act_d  = '0; m_pend_d = '0;
        m_act_b  = '1; m_pend_b = '1;
        m_act_p  = '0; m_pend_p = '0;
        m_pend_v = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int unsigned p, di, c;
        logic lit;
        out_t e;
        p = k % FRAME;
        k++;
        if (p == 0 && m_pend_v) begin
            m_act_d = m_pend_d; m_act_b = m_pend_b; m_act_p = m_pend_p;
            m_pend_v = 1'b0;
        end
        if (load_i) begin
            m_pend_d = digits_i; m_pend_b = blank_i; m_pend_p = dp_i;
            m_pend_v = 1'b1;
        end
        di  = p / DIV;
        c   = p % DIV;
        lit = (c >= GUARD) && !m_act_b[di];
        e.an    = lit ? ~(4'b0001 << di) : 4'b1111;
        e.segs  = lit ? lo(m_act_d[di*4 +: 4]) : 7'h7F;
        e.dp    = lit ? ~m_act_p[di] : 1'b1;
        e.frame = (p == 0);
        exp_q.push_back(e);
    endtask

    function automatic int unsigned phase();
        return (k + FRAME - 1) % FRAME;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        out_t e, got;
        got = {an_o, segs_o, dp_o, frame_o};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry at k=%0d", k);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL scoreboard k=%0d phase=%0d: an=%b segs=%b dp=%b frame=%b, expected an=%b segs=%b dp=%b frame=%b",
                         k, phase(), got.an, got.segs, got.dp, got.frame, e.an, e.segs, e.dp, e.frame);
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, predict, then compare just after the edge.
    task automatic tick(input logic ld);
        load_i   = ld;
        digits_i = st_d;
        blank_i  = st_b;
        dp_i     = st_p;
        @(posedge clk);
        model_edge();
        #1;
        check_pop();
        load_i = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        st_d = d; st_b = b; st_p = p;
        tick(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic goto_phase(input int unsigned target);
        for (int i = 0; i < int'(FRAME) && phase() != target; i++) tick(1'b0);
        chk("goto_phase", 32'(phase()), 32'(target));
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
        int unsigned slot;
        logic [3:0]  an;
        logic [6:0]  segs;
        logic        dp;
    } vec_t;

    vec_t vt[8];

    initial begin
        int last;
        bit found;
        int cnt_a, cnt_b;

        vt[0] = '{16'h1234, 4'b0000, 4'b0001, 0, 4'b1110, 7'b0011001, 1'b0};
        vt[1] = '{16'h1234, 4'b0000, 4'b0001, 1, 4'b1101, 7'b0110000, 1'b1};
        vt[2] = '{16'hFA00, 4'b0000, 4'b0000, 3, 4'b0111, 7'b0001110, 1'b1};
        vt[3] = '{16'hFA00, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0001000, 1'b1};
        vt[4] = '{16'hFA00, 4'b0000, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1};
        vt[5] = '{16'h5678, 4'b0100, 4'b1000, 2, 4'b1111, 7'b1111111, 1'b1};
        vt[6] = '{16'h5678, 4'b0100, 4'b1000, 3, 4'b0111, 7'b0010010, 1'b0};
        vt[7] = '{16'hC0DE, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0000110, 1'b1};

        rst = 1'b1; load_i = 1'b0; digits_i = '0; blank_i = '0; dp_i = '0;
        st_d = '0; st_b = '0; st_p = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({an_o, segs_o, dp_o, frame_o}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));

        // Release and idle: dark display, frame pulse on the first edge and every FRAME cycles.
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        chk("first_frame_after_reset", 32'(frame_o), 32'd1);
        last = 1;
        for (int t = 2; t <= 3 * int'(FRAME) + 1; t++) begin
            tick(1'b0);
            if (frame_o) begin
                chk("frame_period", 32'(t - last), 32'(FRAME));
                last = t;
            end
        end

        // Table: load, wait for the boundary, inspect one slot against fixed patterns.
        for (int i = 0; i < 8; i++) begin
            do_load(vt[i].d, vt[i].b, vt[i].p);
            found = 1'b0;
            for (int t = 0; t <= int'(FRAME) && !found; t++) begin
                tick(1'b0);
                if (frame_o) found = 1'b1;
            end
            chk($sformatf("vec%0d_boundary", i), 32'(found), 32'd1);
            goto_phase(vt[i].slot * DIV);
            for (int c = 0; c < int'(DIV); c++) begin
                if (c < int'(GUARD))
                    chk($sformatf("vec%0d_guard%0d", i, c), 32'({an_o, segs_o, dp_o}), 32'({4'hF, 7'h7F, 1'b1}));
                else
                    chk($sformatf("vec%0d_lit%0d", i, c), 32'({an_o, segs_o, dp_o}), 32'({vt[i].an, vt[i].segs, vt[i].dp}));
                if (c < int'(DIV) - 1) tick(1'b0);
            end
        end

        // Blanked digit 2 never lights over 10 frames; the other three keep their 8 lit cycles.
        do_load(16'h1234, 4'b0100, 4'b0000);
        idle(FRAME + 1);
        cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < 10 * int'(FRAME); t++) begin
            tick(1'b0);
            if (an_o == 4'b1011) cnt_a++;
            if (an_o != 4'b1111) cnt_b++;
        end
        chk("blanked_anode_seen", 32'(cnt_a), 32'd0);
        chk("unblanked_lit_cycles", 32'(cnt_b), 32'd240);

        // Two loads in one frame: current frame stays old, next frame shows only the last load.
        do_load(16'h3333, 4'b0000, 4'b0000);
        idle(FRAME + 1);
        goto_phase(0);
        cnt_a = 0; cnt_b = 0;
        for (int t = 1; t < int'(FRAME); t++) begin
            if (t == 5) do_load(16'h1111, 4'b0000, 4'b0000);
            else if (t == 20) do_load(16'h2222, 4'b0000, 4'b0000);
            else tick(1'b0);
            if (an_o != 4'b1111 && segs_o == lo(4'h3)) cnt_a++;
            if (an_o != 4'b1111 && segs_o != lo(4'h3)) cnt_b++;
        end
        chk("old_frame_old_lit", 32'(cnt_a), 32'd32);
        chk("old_frame_new_leak", 32'(cnt_b), 32'd0);
        cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < int'(FRAME); t++) begin
            tick(1'b0);
            if (an_o != 4'b1111 && segs_o == lo(4'h2)) cnt_a++;
            if (an_o != 4'b1111 && segs_o != lo(4'h2)) cnt_b++;
        end
        chk("new_frame_last_load_lit", 32'(cnt_a), 32'd32);
        chk("new_frame_other_lit", 32'(cnt_b), 32'd0);

        // Load on the boundary edge itself: visible only one frame later.
        goto_phase(FRAME - 1);
        do_load(16'h4444, 4'b0000, 4'b0000);
        chk("boundary_load_frame", 32'(frame_o), 32'd1);
        cnt_a = 0;
        for (int t = 1; t < int'(FRAME); t++) begin
            tick(1'b0);
            if (an_o != 4'b1111 && segs_o != lo(4'h2)) cnt_a++;
        end
        chk("boundary_load_not_yet", 32'(cnt_a), 32'd0);
        cnt_a = 0;
        for (int t = 0; t < int'(FRAME); t++) begin
            tick(1'b0);
            if (an_o != 4'b1111 && segs_o == lo(4'h4)) cnt_a++;
        end
        chk("boundary_load_visible", 32'(cnt_a), 32'd32);

        // Asynchronous reset in the middle of a lit slot.
        goto_phase(DIV + 5);
        chk("pre_reset_lit", 32'({an_o, segs_o}), 32'({4'b1101, lo(4'h4)}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({an_o, segs_o, dp_o, frame_o}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_outputs", 32'({an_o, segs_o, dp_o, frame_o}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(1'b0);
        chk("frame_after_mid_reset", 32'(frame_o), 32'd1);
        cnt_a = 0;
        for (int t = 0; t < 2 * int'(FRAME); t++) begin
            tick(1'b0);
            if (an_o != 4'b1111) cnt_a++;
        end
        chk("dark_after_mid_reset", 32'(cnt_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
